uart_rx_os: RTL and testbench

- Oversampling UART receiver; the receiving end for the serial line driven by uart_tx.
- Takes an asynchronous serial input and synchronises it, then qualifies the start bit.
- Majority-votes each bit at mid-bit, checks parity and stop bit.
- Presents each byte on a valid/ready handshake, with error flags, to the downstream consumer (register block or FIFO).

---
 rtl/uart_rx_os.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver with 2-of-3 mid-bit voting, parity and
//            stop-bit checks, and a valid/ready output holding register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] C_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_MID_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_MID    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_MID_P1 = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [BW-1:0] C_NBITS  = BW'(DATA_BITS);
    localparam logic          C_ODD    = (PARITY_ODD != 0);
    localparam logic          C_PAR_EN = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_q,   state_d;
    logic                 sync1_q,   sync1_d;
    logic                 rxs_q,     rxs_d;
    logic                 rxs_prev_q, rxs_prev_d;
    logic                 armed_q,   armed_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic [BW-1:0]        bitn_q,    bitn_d;
    logic [1:0]           samp_q,    samp_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 par_q,     par_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 perr_q,    perr_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;
    logic                 busy_q,    busy_d;

    logic w_fall;
    logic w_vote;
    logic w_decide;
    logic w_wrap;
    logic w_perr;
    logic w_accept;

    // Start detection is blocked until the line has been seen idle once, so a
    // line held low across reset release cannot look like a start edge.
    assign w_fall   = armed_q & rxs_prev_q & ~rxs_q;
    assign w_vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign w_decide = (cnt_q == C_MID_P1);
    assign w_wrap   = (cnt_q == C_LAST);
    assign w_perr   = C_PAR_EN & ((^shift_q) ^ par_q ^ C_ODD);
    assign w_accept = ~valid_q | ready;

    always_comb begin
        state_d    = state_q;
        sync1_d    = rxd;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
        armed_d    = armed_q | rxs_q;
        cnt_d      = w_wrap ? '0 : cnt_q + 1'b1;
        bitn_d     = bitn_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_d      = par_q;
        data_d     = data_q;
        valid_d    = valid_q & ~ready;
        perr_d     = perr_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        busy_d     = busy_q;

        if (cnt_q == C_MID_M1) samp_d[0] = rxs_q;
        if (cnt_q == C_MID)    samp_d[1] = rxs_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_fall) begin
                    state_d = S_START;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (w_decide && w_vote) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (w_wrap) begin
                    state_d = S_DATA;
                    bitn_d  = '0;
                end
            end
            S_DATA: begin
                if (w_decide) begin
                    shift_d = {w_vote, shift_q[DATA_BITS-1:1]};
                    bitn_d  = bitn_q + 1'b1;
                end
                if (w_wrap && (bitn_q == C_NBITS)) begin
                    state_d = C_PAR_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_decide) par_d = w_vote;
                if (w_wrap)   state_d = S_STOP;
            end
            S_STOP: begin
                if (w_decide) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                    if (w_vote) begin
                        state_d = S_IDLE;
                        // A completing handshake frees the holding register this cycle.
                        if (w_accept) begin
                            data_d  = shift_q;
                            perr_d  = w_perr;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        state_d = S_BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            bitn_q     <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            bitn_q     <= bitn_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
// ============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Directed scoreboard bench for uart_rx_os (even and odd parity).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_os;

    localparam int CPB = 16;
    localparam int MID = CPB / 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       tx    = 1'b1;
    logic       sel   = 1'b0;
    logic       ready = 1'b1;
    logic       rxd_a, rxd_b;

    logic [7:0] data_a, data_b;
    logic       valid_a, perr_a, fe_a, ov_a, busy_a;
    logic       valid_b, perr_b, fe_b, ov_b, busy_b;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int   checks   = 0;
    int   failures = 0;
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;
    int   hs_cnt   = 0;
    int   b_cnt    = 0;
    int   b_err    = 0;
    logic [7:0] b_data = 8'h00;
    logic       b_perr = 1'b1;

    always #5 clk = ~clk;

    assign rxd_a = sel ? 1'b1 : tx;
    assign rxd_b = sel ? tx : 1'b1;

    uart_rx_os u_dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd_a),
        .data       (data_a),
        .valid      (valid_a),
        .ready      (ready),
        .parity_err (perr_a),
        .frame_err  (fe_a),
        .overrun    (ov_a),
        .busy       (busy_a)
    );

    uart_rx_os #(.PARITY_ODD(1)) u_dut_odd (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd_b),
        .data       (data_b),
        .valid      (valid_b),
        .ready      (1'b1),
        .parity_err (perr_b),
        .frame_err  (fe_b),
        .overrun    (ov_b),
        .busy       (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every completed handshake, plus pulse counters.
    always @(negedge clk) begin
        if (reset) begin
            if (valid_a && ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(valid_a), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(data_a), 32'(e.d));
                    check("sb_parity_err", 32'(perr_a), 32'(e.p));
                    hs_cnt++;
                end
            end
            if (fe_a || ov_a) check("fe_ov_exclusive", 32'(fe_a & ov_a), 32'd0);
            if (fe_a) fe_cnt++;
            if (ov_a) ov_cnt++;
            if (valid_b) begin
                b_cnt++;
                b_data = data_b;
                b_perr = perr_b;
            end
            if (fe_b || ov_b) b_err++;
        end
    end

    // Serial frame driver; rst_at >= 0 asserts reset at that bit-cycle index.
    task automatic send(input logic [7:0] d, input bit par_inv, input bit stop_low,
                        input bit odd, input logic [10:0] spike, input int rst_at,
                        output bit aborted);
        logic [10:0] bits;
        int n;
        bits[0]    = 1'b0;
        bits[8:1]  = d;
        bits[9]    = (^d) ^ odd ^ par_inv;
        bits[10]   = ~stop_low;
        aborted    = 1'b0;
        n          = 0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                if (n == rst_at) begin
                    #2;
                    check("busy_before_reset", 32'(busy_a), 32'd1);
                    reset = 1'b0;
                    #1;
                    check("rst_data", 32'(data_a), 32'd0);
                    check("rst_valid", 32'(valid_a), 32'd0);
                    check("rst_parity_err", 32'(perr_a), 32'd0);
                    check("rst_frame_err", 32'(fe_a), 32'd0);
                    check("rst_overrun", 32'(ov_a), 32'd0);
                    check("rst_busy", 32'(busy_a), 32'd0);
                    tx = 1'b1;
                    repeat (3) @(posedge clk);
                    @(negedge clk);
                    reset   = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                tx = bits[b] ^ (spike[b] && (c == 9));
                n++;
            end
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clk);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  f0, o0, h0, len;
        bit  ab;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(data_a), 32'd0);
        check("reset_valid", 32'(valid_a), 32'd0);
        check("reset_parity_err", 32'(perr_a), 32'd0);
        check("reset_frame_err", 32'(fe_a), 32'd0);
        check("reset_overrun", 32'(ov_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // Back-to-back frames with ready high.
        f0 = fe_cnt; o0 = ov_cnt; h0 = hs_cnt;
        sb.push_back({8'h56, 1'b0});
        send(8'h56, 0, 0, 0, '0, -1, ab);
        sb.push_back({8'h69, 1'b0});
        send(8'h69, 0, 0, 0, '0, -1, ab);
        sb.push_back({8'h76, 1'b0});
        send(8'h76, 0, 0, 0, '0, -1, ab);
        wait_drain(400);
        check("b2b_handshakes", 32'(hs_cnt - h0), 32'd3);
        check("b2b_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("b2b_overrun", 32'(ov_cnt - o0), 32'd0);

        // Inverted parity bit.
        sb.push_back({8'h65, 1'b1});
        send(8'h65, 1, 0, 0, '0, -1, ab);
        wait_drain(400);

        // Odd-parity instance, correct odd parity.
        sel = 1'b1;
        send(8'h6B, 0, 0, 1, '0, -1, ab);
        repeat (4) @(posedge clk);
        sel = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("odd_count", 32'(b_cnt), 32'd1);
        check("odd_data", 32'(b_data), 32'h6B);
        check("odd_parity_err", 32'(b_perr), 32'd0);
        check("odd_errors", 32'(b_err), 32'd0);
        check("odd_busy_idle", 32'(busy_b), 32'd0);

        // Framing error followed by a held-low line.
        f0 = fe_cnt; h0 = hs_cnt;
        send(8'h6B, 0, 1, 0, '0, -1, ab);
        repeat (40) @(posedge clk);
        tx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("ferr_pulse_cycles", 32'(fe_cnt - f0), 32'd1);
        check("ferr_no_valid", 32'(hs_cnt - h0), 32'd0);
        check("ferr_busy_idle", 32'(busy_a), 32'd0);
        sb.push_back({8'h56, 1'b0});
        send(8'h56, 0, 0, 0, '0, -1, ab);
        wait_drain(400);
        check("ferr_recover_count", 32'(fe_cnt - f0), 32'd1);

        // Overrun: second frame arrives while the first is still held.
        @(posedge clk);
        ready = 1'b0;
        o0 = ov_cnt; f0 = fe_cnt; h0 = hs_cnt;
        sb.push_back({8'h56, 1'b0});
        send(8'h56, 0, 0, 0, '0, -1, ab);
        send(8'h69, 0, 0, 0, '0, -1, ab);
        repeat (2) @(posedge clk);
        #1;
        check("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
        check("ovr_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("ovr_valid_held", 32'(valid_a), 32'd1);
        check("ovr_data_held", 32'(data_a), 32'h56);
        check("ovr_pending", 32'(sb.size()), 32'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_valid_drop", 32'(valid_a), 32'd0);
        repeat (100) @(posedge clk);
        #1;
        check("ovr_single_word", 32'(hs_cnt - h0), 32'd1);
        check("ovr_queue_empty", 32'(sb.size()), 32'd0);

        // Short start glitch from idle.
        o0 = ov_cnt; f0 = fe_cnt; h0 = hs_cnt;
        @(posedge clk);
        tx = 1'b0;
        repeat (5) @(posedge clk);
        tx = 1'b1;
        len = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy_a) len++;
        end
        check("glitch_busy_seen", 32'(len > 0), 32'd1);
        check("glitch_busy_short", 32'(len <= MID + 2), 32'd1);
        check("glitch_no_valid", 32'(hs_cnt - h0), 32'd0);
        check("glitch_no_ferr", 32'(fe_cnt - f0), 32'd0);
        check("glitch_no_ovr", 32'(ov_cnt - o0), 32'd0);

        // One-cycle spikes at mid-bit of data bits 1 (low) and 3 (high).
        sb.push_back({8'h56, 1'b0});
        send(8'h56, 0, 0, 0, 11'b000_0001_0100, -1, ab);
        wait_drain(400);

        // Reset during data bit 4, then a clean frame.
        sb.push_back({8'h69, 1'b0});
        send(8'h69, 0, 0, 0, '0, 5 * CPB + 8, ab);
        if (ab) sb.pop_back();
        check("rst_aborted", 32'(ab), 32'd1);
        repeat (4) @(posedge clk);
        sb.push_back({8'h69, 1'b0});
        send(8'h69, 0, 0, 0, '0, -1, ab);
        wait_drain(400);
        repeat (10) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
